// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : Y86-64 fetch sequencer. It holds the predicted PC, sizes the
// returned instruction, predicts the next PC and fills the F->D register.
// Optional macro FETCH_BTFN_EN: conditional jXX backward-taken/forward-not.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter int                  DATA_WID  = 64,
  parameter int                  MEM_BYTES = 2048,
  parameter logic [DATA_WID-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_stall,
  input  logic                redirect_valid,
  input  logic [DATA_WID-1:0] redirect_pc,
  input  logic                ret_valid,
  input  logic [DATA_WID-1:0] ret_pc,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [3:0]          rA,
  input  logic [3:0]          rB,
  input  logic [DATA_WID-1:0] valC,
  output logic [DATA_WID-1:0] PC,
  output logic [2:0]          D_stat,
  output logic [3:0]          D_icode,
  output logic [3:0]          D_ifun,
  output logic [3:0]          D_rA,
  output logic [3:0]          D_rB,
  output logic [DATA_WID-1:0] D_valC,
  output logic [DATA_WID-1:0] D_valP,
  output logic [DATA_WID-1:0] D_pc,
  output logic [1:0]          fetch_state
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  logic [DATA_WID-1:0] r_pred_pc;
  logic [1:0]          r_state;

  logic [3:0]          w_len;
  logic                w_ins_bad;
  logic [DATA_WID-1:0] w_valp;
  logic [DATA_WID:0]   w_end_addr;
  logic [2:0]          w_stat;
  logic                w_use_valc;
  logic [DATA_WID-1:0] w_pred_next;

  assign PC          = r_pred_pc;
  assign fetch_state = r_state;

  always_comb begin
    w_len     = 4'd1;
    w_ins_bad = 1'b0;
    case (icode)
      4'h0, 4'h1, 4'h9:       w_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
      4'h7, 4'h8:             w_len = 4'd9;
      4'h3, 4'h4, 4'h5:       w_len = 4'd10;
      default:                w_ins_bad = 1'b1;
    endcase
  end

  // Bounds check is done one bit wider so a PC near the top cannot wrap past it.
  assign w_valp     = r_pred_pc + DATA_WID'(w_len);
  assign w_end_addr = {1'b0, r_pred_pc} + (DATA_WID+1)'(w_len);

  always_comb begin
    if (w_ins_bad)                                 w_stat = STAT_INS;
    else if (w_end_addr > (DATA_WID+1)'(MEM_BYTES)) w_stat = STAT_ADR;
    else if (icode == 4'h0)                        w_stat = STAT_HLT;
    else                                           w_stat = STAT_AOK;
  end

`ifdef FETCH_BTFN_EN
  // Conditional jumps are taken only when they go backward (loop closers).
  assign w_use_valc = (icode == 4'h8) ||
                      ((icode == 4'h7) && ((ifun == 4'h0) || (valC < r_pred_pc)));
`else
  assign w_use_valc = (icode == 4'h7) || (icode == 4'h8);
`endif

  assign w_pred_next = w_use_valc ? valC : w_valp;

  always_ff @(posedge clk) begin
    if (rst || redirect_valid || (r_state == ST_RET_WAIT && ret_valid)) begin
      if (rst)                 r_pred_pc <= RESET_PC;
      else if (redirect_valid) r_pred_pc <= redirect_pc;
      else                     r_pred_pc <= ret_pc;
      r_state <= ST_RUN;
      D_stat  <= STAT_AOK;
      D_icode <= 4'h1;
      D_ifun  <= 4'h0;
      D_rA    <= 4'hF;
      D_rB    <= 4'hF;
      D_valC  <= '0;
      D_valP  <= '0;
      D_pc    <= '0;
    end else if (!f_stall) begin
      if (r_state == ST_RUN) begin
        D_stat  <= w_stat;
        D_icode <= icode;
        D_ifun  <= ifun;
        D_rA    <= rA;
        D_rB    <= rB;
        D_valC  <= valC;
        D_valP  <= w_valp;
        D_pc    <= r_pred_pc;
        if (w_stat != STAT_AOK)  r_state <= ST_HALT;
        else if (icode == 4'h9)  r_state <= ST_RET_WAIT;
        else                     r_pred_pc <= w_pred_next;
      end else begin
        // Waiting for ret or halted: bubble, keeping any halting stat visible.
        if (r_state == ST_RET_WAIT) D_stat <= STAT_AOK;
        D_icode <= 4'h1;
        D_ifun  <= 4'h0;
        D_rA    <= 4'hF;
        D_rB    <= 4'hF;
        D_valC  <= '0;
        D_valP  <= '0;
        D_pc    <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expectations are queued as each step is
// driven and popped for comparison after the clock edge that consumes it.
`default_nettype none

module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, f_stall, redirect_valid, ret_valid;
  logic [63:0] redirect_pc, ret_pc, valC;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] PC, D_valC, D_valP, D_pc;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [1:0]  fetch_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  st;
    logic [2:0]  stat;
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] c, p, dpc;
    bit          cv;
  } exp_t;

  exp_t sb[$];

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .f_stall(f_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ret_valid(ret_valid), .ret_pc(ret_pc),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .PC(PC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .D_pc(D_pc), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c);
    icode = ic; ifun = fn; valC = c; rA = 4'h2; rB = 4'h3;
  endtask

  task automatic exp_f(input logic [63:0] npc, input logic [1:0] st, input logic [2:0] stat,
                       input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                       input logic [63:0] p, input logic [63:0] dpc, input bit cv);
    exp_t e;
    e.pc = npc; e.st = st; e.stat = stat; e.ic = ic; e.fn = fn; e.ra = 4'h2; e.rb = 4'h3;
    e.c = c; e.p = p; e.dpc = dpc; e.cv = cv;
    sb.push_back(e);
  endtask

  task automatic exp_bub(input logic [63:0] npc, input logic [1:0] st, input logic [2:0] stat);
    exp_t e;
    e.pc = npc; e.st = st; e.stat = stat; e.ic = 4'h1; e.fn = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
    e.c = 64'd0; e.p = 64'd0; e.dpc = 64'd0; e.cv = 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      cmp({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      cmp({tag, "_PC"}, PC, e.pc);
      cmp({tag, "_state"}, 64'(fetch_state), 64'(e.st));
      cmp({tag, "_stat"}, 64'(D_stat), 64'(e.stat));
      cmp({tag, "_icode"}, 64'(D_icode), 64'(e.ic));
      cmp({tag, "_ifun"}, 64'(D_ifun), 64'(e.fn));
      cmp({tag, "_rA"}, 64'(D_rA), 64'(e.ra));
      cmp({tag, "_rB"}, 64'(D_rB), 64'(e.rb));
      cmp({tag, "_valC"}, D_valC, e.c);
      if (e.cv) cmp({tag, "_valP"}, D_valP, e.p);
      cmp({tag, "_pc"}, D_pc, e.dpc);
    end
  endtask

  task automatic redirect_to(input logic [63:0] a, input string tag);
    redirect_valid = 1'b1; redirect_pc = a;
    exp_bub(a, 2'd0, 3'd1);
    tick_check(tag);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; f_stall = 1'b0; redirect_valid = 1'b0; ret_valid = 1'b0;
    redirect_pc = '0; ret_pc = '0;
    fetch(4'h1, 4'h0, 64'd0);
    exp_bub(64'd0, 2'd0, 3'd1);
    tick_check("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fetch(4'h1, 4'h0, 64'd0);
      exp_f(64'(i + 1), 2'd0, 3'd1, 4'h1, 4'h0, 64'd0, 64'(i + 1), 64'(i), 1'b1);
      tick_check("nop");
    end

    redirect_to(64'h10, "redir10");
    fetch(4'h3, 4'h0, 64'h55);
    exp_f(64'h1A, 2'd0, 3'd1, 4'h3, 4'h0, 64'h55, 64'h1A, 64'h10, 1'b1);
    tick_check("irmovq");
    fetch(4'h8, 4'h0, 64'h100);
    exp_f(64'h100, 2'd0, 3'd1, 4'h8, 4'h0, 64'h100, 64'h23, 64'h1A, 1'b1);
    tick_check("call");
    fetch(4'h9, 4'h0, 64'd0);
    exp_f(64'h100, 2'd1, 3'd1, 4'h9, 4'h0, 64'd0, 64'h101, 64'h100, 1'b1);
    tick_check("ret");
    for (int i = 0; i < 3; i++) begin
      exp_bub(64'h100, 2'd1, 3'd1);
      tick_check("retwait");
    end
    ret_valid = 1'b1; ret_pc = 64'h23;
    exp_bub(64'h23, 2'd0, 3'd1);
    tick_check("retres");

    // ret_valid while running must be ignored
    ret_pc = 64'h999;
    fetch(4'h1, 4'h0, 64'd0);
    exp_f(64'h24, 2'd0, 3'd1, 4'h1, 4'h0, 64'd0, 64'h24, 64'h23, 1'b1);
    tick_check("retign");
    ret_valid = 1'b0;

    f_stall = 1'b1;
    fetch(4'h3, 4'h0, 64'h77);
    for (int i = 0; i < 2; i++) begin
      exp_f(64'h24, 2'd0, 3'd1, 4'h1, 4'h0, 64'd0, 64'h24, 64'h23, 1'b1);
      tick_check("stall");
    end
    redirect_to(64'h100, "stall_redir");
    f_stall = 1'b0;

    fetch(4'h9, 4'h0, 64'd0);
    exp_f(64'h100, 2'd1, 3'd1, 4'h9, 4'h0, 64'd0, 64'h101, 64'h100, 1'b1);
    tick_check("ret2");
    f_stall = 1'b1; ret_valid = 1'b1; ret_pc = 64'h23;
    exp_bub(64'h23, 2'd0, 3'd1);
    tick_check("retstall");
    f_stall = 1'b0; ret_valid = 1'b0;

    redirect_to(64'h40, "redir40");
    fetch(4'hC, 4'h0, 64'd0);
    exp_f(64'h40, 2'd2, 3'd4, 4'hC, 4'h0, 64'd0, 64'd0, 64'h40, 1'b0);
    tick_check("ins");
    ret_valid = 1'b1;
    exp_bub(64'h40, 2'd2, 3'd4);
    tick_check("halt_hold");
    ret_valid = 1'b0;
    redirect_to(64'h8, "redir8");

    redirect_to(64'h7F6, "redir7f6");
    fetch(4'h3, 4'h0, 64'h7);
    exp_f(64'h800, 2'd0, 3'd1, 4'h3, 4'h0, 64'h7, 64'h800, 64'h7F6, 1'b1);
    tick_check("edge_ok");
    fetch(4'h1, 4'h0, 64'd0);
    exp_f(64'h800, 2'd2, 3'd3, 4'h1, 4'h0, 64'd0, 64'h801, 64'h800, 1'b1);
    tick_check("adr_nop");
    redirect_to(64'h7FA, "redir7fa");
    fetch(4'h3, 4'h0, 64'h7);
    exp_f(64'h7FA, 2'd2, 3'd3, 4'h3, 4'h0, 64'h7, 64'h804, 64'h7FA, 1'b1);
    tick_check("adr_irm");

    redirect_to(64'h60, "redir60");
    fetch(4'h0, 4'h0, 64'd0);
    exp_f(64'h60, 2'd2, 3'd2, 4'h0, 4'h0, 64'd0, 64'h61, 64'h60, 1'b1);
    tick_check("halt");

    redirect_to(64'h50, "redir50a");
    fetch(4'h7, 4'h4, 64'h20);
    exp_f(64'h20, 2'd0, 3'd1, 4'h7, 4'h4, 64'h20, 64'h59, 64'h50, 1'b1);
    tick_check("jne_back");
    redirect_to(64'h50, "redir50b");
    fetch(4'h7, 4'h4, 64'h80);
`ifdef FETCH_BTFN_EN
    exp_f(64'h59, 2'd0, 3'd1, 4'h7, 4'h4, 64'h80, 64'h59, 64'h50, 1'b1);
`else
    exp_f(64'h80, 2'd0, 3'd1, 4'h7, 4'h4, 64'h80, 64'h59, 64'h50, 1'b1);
`endif
    tick_check("jne_fwd");
    redirect_to(64'h50, "redir50c");
    fetch(4'h7, 4'h0, 64'h80);
    exp_f(64'h80, 2'd0, 3'd1, 4'h7, 4'h0, 64'h80, 64'h59, 64'h50, 1'b1);
    tick_check("jmp");

    cmp("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Y86-64 fetch-stage sequencer, directly upstream of the instruction memory.
- Owns the predicted-PC register and drives PC to the instruction memory.
- Consumes the decoded icode/ifun/rA/rB/valC returned for that PC, computes instruction length and valP, and predicts the next PC.
- Latches the fetched fields into the F→D pipeline register.
- Handles stall, branch redirect, ret resolution and halt/exception stop.

Parameters:
DATA_WID, 64, address/data width
MEM_BYTES, 2048, instruction memory size in bytes; bounds check limit
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
f_stall  in  1  hold PC and D register (hazard unit)
redirect_valid  in  1  mispredicted branch / wrong-path correction
redirect_pc  in  64  correct PC for redirect
ret_valid  in  1  ret return address available
ret_pc  in  64  return address
icode  in  4  from instruction memory for current PC
ifun  in  4  from instruction memory
rA  in  4  from instruction memory
rB  in  4  from instruction memory
valC  in  64  from instruction memory
PC  out  64  fetch address to instruction memory (combinational from predPC register)
D_stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
D_icode  out  4  latched icode
D_ifun  out  4  latched ifun
D_rA  out  4  latched rA
D_rB  out  4  latched rB
D_valC  out  64  latched valC
D_valP  out  64  latched PC+length
D_pc  out  64  latched PC of this instruction
fetch_state  out  2  0=RUN 1=RET_WAIT 2=HALT

Behaviour:
- Reset (synchronous, active-high, one edge):
  - predPC=RESET_PC, state=RUN.
  - D register = bubble: icode=1 (nop), ifun=0, rA=rB=F, valC=0, valP=0, pc=0, stat=AOK.
- Length by icode:
  - 0, 1, 9 → 1 byte.
  - 2, 6, A, B → 2 bytes.
  - 7, 8 → 9 bytes.
  - 3, 4, 5 → 10 bytes.
  - icode>B → invalid.
- valP = PC + length, DATA_WID bits, wraps modulo 2^64.
- Status priority: invalid icode → INS; else PC+length > MEM_BYTES → ADR; else icode 0 → HLT; else AOK.
- Prediction: icode 7/8 → valC; otherwise valP. icode 9 → next state RET_WAIT.
- Latency: fields for PC appear on D_* one edge after PC is presented.
- Priority per edge: rst > redirect_valid > ret_valid (RET_WAIT only) > f_stall > normal.
- RUN:
  - Normal edge: D ← fetched fields, predPC ← prediction.
  - stat≠AOK → D ← fetched fields with that stat; predPC held; state → HALT.
  - icode 9 → D ← ret; predPC held; state → RET_WAIT.
- RET_WAIT:
  - D ← bubble each edge; predPC held.
  - ret_valid → predPC ← ret_pc, D ← bubble, state → RUN.
- HALT:
  - D ← bubble with stat held at the halting stat; predPC held.
  - Left only by redirect or reset.
- redirect_valid, any state: predPC ← redirect_pc, D ← bubble (stat AOK), state → RUN. Overrides a simultaneous f_stall or ret_valid.
- f_stall (no redirect): predPC and all D_* hold. State holds, except a ret_valid in RET_WAIT is still taken.
- ret_valid outside RET_WAIT is ignored.
- fetch_state reflects the registered state.

Optional Feature:
FETCH_BTFN_EN:
- Defined: conditional jXX (icode 7, ifun≠0) predicts valC only if valC < PC (backward), else valP. Unconditional jmp and call still predict valC.
- Undefined: all jXX predict valC (always-taken).
- Redirect handling identical in both builds.

Test Plan:
- Reset then nop stream (icode 1) → PC 0,1,2,3 on successive cycles; D_valP = PC+1; D_stat=1.
- irmovq at PC 0x10 (icode 3, valC 0x55) → D_valC=0x55, D_valP=0x1A, next PC=0x1A. call at 0x1A with valC 0x100 → next PC=0x100, D_valP=0x23.
- ret at 0x100 → fetch_state=1, three bubbles while ret_valid=0; ret_valid with ret_pc 0x23 → next PC=0x23, state 0. Repeat with f_stall=1 asserted on the ret_valid edge → still resumes at 0x23.
- Fetch icode 0xC at 0x40 → D_stat=4, state=2, PC stays 0x40. redirect_valid, redirect_pc 0x8 → PC=0x8, state 0, D bubble AOK. Also: irmovq at 0x7FA (0x7FA+10 > 2048) → D_stat=3.
- f_stall=1 for 2 cycles mid-stream → PC and D_* unchanged. f_stall and redirect_valid together → redirect wins.
- FETCH_BTFN_EN build: jne at 0x50 with valC 0x20 → predict 0x20; with valC 0x80 → predict 0x59. Without the macro, both cases predict valC.
